perceptron_sample_loader: RTL and testbench

- Upstream feeder for the perceptron stage: accepts a byte stream of training/inference samples, assembles each 2-byte frame into a sample, buffers samples in a small FIFO, and presents one sample at a time on the perceptron's input vector, threshold and expected-result ports.
- Holds each sample stable for a programmable number of cycles so the perceptron can settle and score it.
- Emits a one-cycle strobe whenever a new sample is applied.

---
 rtl/perceptron_sample_loader.sv | 148 ++++++++++++++
 tb/tb_perceptron_sample_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_sample_loader.sv
// Byte-stream front end for the perceptron: assembles 2-byte frames into samples,
// queues them in a small FIFO and applies each one for HOLD_CYCLES cycles.
module perceptron_sample_loader #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic                     flush,
  output logic [6:0]               pc_in,
  output logic [7:0]               pc_threshold,
  output logic                     pc_exp_res,
  output logic                     sample_strobe,
  output logic                     busy,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0] threshold;
    logic       exp_res;
    logic [6:0] in;
  } sample_t;

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

  logic          phase_q, phase_d;
  logic [7:0]    byte0_q, byte0_d;
  logic          xfer, push, pop;
  sample_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d, full_q, full_d;
  state_t        state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  sample_t       pc_q, pc_d;

  // Backpressure ignores frame phase, so a full FIFO stalls byte0 as well as byte1.
  assign xfer = data_valid && !full_q;
  assign push = xfer && phase_q && !flush;

  always_comb begin
    phase_d = phase_q;
    byte0_d = byte0_q;
    if (flush) begin
      phase_d = 1'b0;
    end else if (xfer) begin
      phase_d = !phase_q;
      if (!phase_q) byte0_d = data_in;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
  end

  // APPLY and HOLD share the exit rule, which makes HOLD_CYCLES=1 fall out naturally.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pc_d    = pc_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: pop = !empty_q;
      APPLY, HOLD: begin
        if (hold_q == '0) begin
          pop = !empty_q;
          if (empty_q) state_d = IDLE;
        end else begin
          hold_d  = hold_q - CW'(1);
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = APPLY;
      hold_d  = HOLD_LOAD;
      pc_d    = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= 1'b0;
      byte0_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      state_q  <= IDLE;
      hold_q   <= '0;
      pc_q     <= '0;
    end else begin
      phase_q  <= phase_d;
      byte0_q  <= byte0_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      pc_q     <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {data_in, byte0_q};
  end

  assign data_ready    = !full_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign count         = count_q;
  assign busy          = (state_q != IDLE);
  assign sample_strobe = (state_q == APPLY);
  assign pc_in         = pc_q.in;
  assign pc_threshold  = pc_q.threshold;
  assign pc_exp_res    = pc_q.exp_res;

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Directed bench for perceptron_sample_loader: two instances (HOLD 4 and HOLD 8),
// a sample scoreboard checked on every strobe, and timing checks on strobes/busy.
module tb_perceptron_sample_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] di;
  logic       dv, fl, sel;

  logic       rdy_a, exp_a, st_a, busy_a, emp_a, full_a;
  logic [6:0] in_a;
  logic [7:0] thr_a;
  logic [2:0] cnt_a;
  logic       rdy_b, exp_b, st_b, busy_b, emp_b, full_b;
  logic [6:0] in_b;
  logic [7:0] thr_b;
  logic [2:0] cnt_b;

  logic       o_ready, o_exp, o_strobe, o_busy, o_empty;
  logic [6:0] o_in;
  logic [7:0] o_thr;
  logic [2:0] o_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int max_cnt  = 0;
  bit saw_nrdy = 0;
  logic [15:0] sb [$];
  int strobe_cycs [$];

  always #5 clk = ~clk;

  perceptron_sample_loader #(.DEPTH(4), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .data_in(di), .data_valid(dv && !sel), .data_ready(rdy_a),
    .flush(fl && !sel), .pc_in(in_a), .pc_threshold(thr_a), .pc_exp_res(exp_a),
    .sample_strobe(st_a), .busy(busy_a), .empty(emp_a), .full(full_a), .count(cnt_a));

  perceptron_sample_loader #(.DEPTH(4), .HOLD_CYCLES(8)) dut_b (
    .clk(clk), .reset(reset), .data_in(di), .data_valid(dv && sel), .data_ready(rdy_b),
    .flush(fl && sel), .pc_in(in_b), .pc_threshold(thr_b), .pc_exp_res(exp_b),
    .sample_strobe(st_b), .busy(busy_b), .empty(emp_b), .full(full_b), .count(cnt_b));

  assign o_ready  = sel ? rdy_b  : rdy_a;
  assign o_exp    = sel ? exp_b  : exp_a;
  assign o_strobe = sel ? st_b   : st_a;
  assign o_busy   = sel ? busy_b : busy_a;
  assign o_empty  = sel ? emp_b  : emp_a;
  assign o_in     = sel ? in_b   : in_a;
  assign o_thr    = sel ? thr_b  : thr_a;
  assign o_count  = sel ? cnt_b  : cnt_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, strobes scored here.
  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (o_busy) busy_cnt++;
    if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
    if (!o_ready) saw_nrdy = 1;
    if (o_strobe) begin
      strobe_cycs.push_back(cyc);
      chk("sb_nonempty_on_strobe", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sample", 32'({o_thr, o_exp, o_in}), 32'(e));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    di = b;
    dv = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      done = o_ready;
      tick();
    end
    chk("byte_accepted", 32'(done), 1);
    dv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input bit keep);
    send_byte(b0);
    send_byte(b1);
    if (keep) sb.push_back({b1, b0});
  endtask

  initial begin
    int p, s0;
    reset = 1'b1; di = 8'hAA; dv = 1'b1; fl = 1'b0; sel = 1'b0;
    tick(); tick();
    chk("rst_pc_in", 32'(o_in), 0);
    chk("rst_pc_thr", 32'(o_thr), 0);
    chk("rst_pc_exp", 32'(o_exp), 0);
    chk("rst_strobe", 32'(o_strobe), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_full", 32'(full_a), 0);
    reset = 1'b0; dv = 1'b0;
    tick();
    chk("rst_no_push_empty", 32'(o_empty), 1);
    chk("rst_no_push_count", 32'(o_count), 0);

    // single sample
    s0 = strobe_cycs.size(); busy_cnt = 0;
    send_frame(8'h85, 8'h20, 1);
    p = cyc;
    chk("single_empty_next", 32'(o_empty), 0);
    repeat (8) tick();
    chk("single_strobes", 32'(strobe_cycs.size()), 32'(s0 + 1));
    if (strobe_cycs.size() > s0) chk("single_latency", 32'(strobe_cycs[s0]), 32'(p + 1));
    chk("single_busy_cycles", 32'(busy_cnt), 4);
    chk("single_keep_in", 32'(o_in), 'h05);
    chk("single_keep_thr", 32'(o_thr), 'h20);
    chk("single_keep_exp", 32'(o_exp), 1);
    chk("single_idle_busy", 32'(o_busy), 0);

    // back-to-back
    s0 = strobe_cycs.size(); busy_cnt = 0;
    send_frame(8'h01, 8'h10, 1);
    send_frame(8'h82, 8'h11, 1);
    send_frame(8'h03, 8'h12, 1);
    repeat (16) tick();
    chk("b2b_strobes", 32'(strobe_cycs.size()), 32'(s0 + 3));
    if (strobe_cycs.size() >= s0 + 3) begin
      chk("b2b_gap1", 32'(strobe_cycs[s0+1] - strobe_cycs[s0]), 4);
      chk("b2b_gap2", 32'(strobe_cycs[s0+2] - strobe_cycs[s0+1]), 4);
    end
    chk("b2b_busy_cycles", 32'(busy_cnt), 12);
    chk("b2b_sb_drained", 32'(sb.size()), 0);

    // full / wrap on the HOLD=8 instance
    sel = 1'b1; max_cnt = 0; saw_nrdy = 0; s0 = strobe_cycs.size();
    for (int i = 0; i < 6; i++) send_frame(8'(i * 37 + 5), 8'(8'h40 + i), 1);
    for (int n = 0; n < 200 && strobe_cycs.size() < s0 + 6; n++) tick();
    chk("full_strobes", 32'(strobe_cycs.size()), 32'(s0 + 6));
    if (strobe_cycs.size() >= s0 + 6)
      for (int i = 1; i < 6; i++)
        chk("full_gap", 32'(strobe_cycs[s0+i] - strobe_cycs[s0+i-1]), 8);
    chk("full_ready_dropped", 32'(saw_nrdy), 1);
    chk("full_max_count", 32'(max_cnt), 4);
    chk("full_sb_drained", 32'(sb.size()), 0);
    repeat (10) tick();
    chk("full_idle", 32'(o_busy), 0);
    sel = 1'b0;

    // byte1 lands on the hold-exit pop with two samples queued
    s0 = strobe_cycs.size();
    send_frame(8'h21, 8'h31, 1);
    p = cyc;
    send_frame(8'hA2, 8'h32, 1);
    send_frame(8'h23, 8'h33, 1);
    send_frame(8'hA4, 8'h34, 1);
    tick();
    send_byte(8'h25);
    chk("pp_schedule", 32'(cyc), 32'(p + 8));
    chk("pp_count_before", 32'(o_count), 2);
    send_byte(8'h35);
    sb.push_back({8'h35, 8'h25});
    chk("pp_count_after", 32'(o_count), 2);
    chk("pp_strobe", 32'(o_strobe), 1);
    repeat (30) tick();
    chk("pp_strobes", 32'(strobe_cycs.size()), 32'(s0 + 5));
    chk("pp_sb_drained", 32'(sb.size()), 0);

    // flush with a buffered sample and a dangling byte0
    s0 = strobe_cycs.size();
    send_frame(8'h11, 8'h22, 1);
    send_frame(8'hC4, 8'h55, 0);
    chk("fl_count_pre", 32'(o_count), 1);
    send_byte(8'h9A);
    fl = 1'b1;
    tick();
    fl = 1'b0;
    chk("fl_count", 32'(o_count), 0);
    chk("fl_empty", 32'(o_empty), 1);
    chk("fl_hold_continues", 32'(o_busy), 1);
    tick();
    chk("fl_hold_done", 32'(o_busy), 0);
    send_frame(8'h07, 8'h33, 1);
    repeat (10) tick();
    chk("fl_strobes", 32'(strobe_cycs.size()), 32'(s0 + 2));
    chk("fl_sb_drained", 32'(sb.size()), 0);

    // reset during HOLD with a sample still buffered
    s0 = strobe_cycs.size();
    send_frame(8'h7F, 8'hFE, 1);
    send_frame(8'h01, 8'h02, 0);
    chk("rh_in_hold", 32'(o_busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rh_busy", 32'(o_busy), 0);
    chk("rh_pc_in", 32'(o_in), 0);
    chk("rh_pc_thr", 32'(o_thr), 0);
    chk("rh_pc_exp", 32'(o_exp), 0);
    chk("rh_empty", 32'(o_empty), 1);
    chk("rh_count", 32'(o_count), 0);
    repeat (12) tick();
    chk("rh_no_stale", 32'(strobe_cycs.size()), 32'(s0 + 1));
    chk("rh_sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
